// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures the period and high time of a slow, asynchronous clock-like
//   signal in cycles of the system clock. Used beside the clock divider to
//   confirm the selected division ratio at runtime.
//
//   Parameters:
//     CNT_W        width of the counters and result outputs
//     SYNC_STAGES  synchronizer depth on sig_in (2 or more)
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     sig_in     measured signal, asynchronous to clk
//     clr        synchronous clear (synchronizer is left running)
//     period     last completed period in clk cycles
//     high_time  cycles the synchronized signal was high in that period
//     valid      one-cycle pulse when period/high_time are updated
//     active     high while a measurement is in progress
//     ovf        sticky: a period ran past the counter range
//     min_period, max_period  running extremes of period
//
//   Optional feature macro: CLK_METER_MINMAX_EN adds min_period/max_period.

module clk_period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             active,
    output logic             ovf
`ifdef CLK_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period
`endif
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic [0:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hcnt;
    logic                   cnt_full;

    // Synchronizer and edge-detect history; clr deliberately does not touch
    // these so an edge already in flight is not lost or duplicated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_d;
    assign cnt_full = &cnt;
    assign active   = (state == ST_MEASURE);

    // cnt/hcnt start at 1 on the edge cycle itself, so the next edge N cycles
    // later sees cnt == N. The all-ones check fires before any wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clr) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                hcnt      <= '0;
                period    <= '0;
                high_time <= '0;
                ovf       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state <= ST_MEASURE;
                            cnt   <= ONE;
                            hcnt  <= ONE;
                        end
                    end
                    ST_MEASURE: begin
                        if (rise) begin
                            period    <= cnt;
                            high_time <= hcnt;
                            valid     <= 1'b1;
                            cnt       <= ONE;
                            hcnt      <= ONE;
                        end else if (cnt_full) begin
                            // Period too long to represent: abandon it and
                            // wait for a fresh edge, keeping the old result.
                            ovf   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + ONE;
                            if (s) hcnt <= hcnt + ONE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef CLK_METER_MINMAX_EN
    // Updated on the same edge that loads period, so the new extremes are
    // visible together with valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_period <= '1;
            max_period <= '0;
        end else if (clr) begin
            min_period <= '1;
            max_period <= '0;
        end else if (state == ST_MEASURE && rise) begin
            if (cnt < min_period) min_period <= cnt;
            if (cnt > max_period) max_period <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

    localparam int CNT_W = 8;
    localparam int S     = 2;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic             valid, active, ovf;
`ifdef CLK_METER_MINMAX_EN
    logic [CNT_W-1:0] min_period, max_period;
`endif

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .clr       (clr),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .active    (active),
        .ovf       (ovf)
`ifdef CLK_METER_MINMAX_EN
        ,
        .min_period(min_period),
        .max_period(max_period)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Event view: the synchronized signal is sig_in delayed by S samples; a
    // measurement is the distance between two consecutive detected rising
    // edges, high time is the count of high samples in that window.
    bit               in_hist [0:65535];
    int               cyc = 0;
    bit               meas = 0;
    int               start = 0;
    logic [CNT_W-1:0] m_period = '0, m_high = '0, m_min = '1, m_max = '0;
    logic             m_valid = 1'b0, m_ovf = 1'b0;

    function automatic bit hv(input int k);
        return (k < 0) ? 1'b0 : in_hist[k];
    endfunction

    task automatic model_step();
        bit e;
        int n, h;
        cyc++;
        in_hist[cyc] = rst ? 1'b0 : sig_in;
        m_valid = 1'b0;
        if (rst) begin
            meas = 0; m_period = '0; m_high = '0; m_ovf = 1'b0;
            m_min = '1; m_max = '0;
            return;
        end
        e = hv(cyc - S) && !hv(cyc - S - 1);
        if (clr) begin
            meas = 0; m_period = '0; m_high = '0; m_ovf = 1'b0;
            m_min = '1; m_max = '0;
        end else if (e) begin
            if (meas) begin
                n = cyc - start;
                h = 0;
                for (int k = start; k < cyc; k++) h += hv(k - S);
                m_period = n[CNT_W-1:0];
                m_high   = h[CNT_W-1:0];
                m_valid  = 1'b1;
                if (m_period < m_min) m_min = m_period;
                if (m_period > m_max) m_max = m_period;
            end
            meas  = 1;
            start = cyc;
        end else if (meas && (cyc - start) >= MAXV) begin
            meas  = 0;
            m_ovf = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (!rst && cyc > 0) begin
            check("period", period, m_period);
            check("high_time", high_time, m_high);
            check("valid", valid, m_valid);
            check("active", active, meas);
            check("ovf", ovf, m_ovf);
`ifdef CLK_METER_MINMAX_EN
            check("min_period", min_period, m_min);
            check("max_period", max_period, m_max);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            sig_in = 1'b1;
            repeat (hi) tick();
            sig_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_high"}, high_time, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_ovf"}, ovf, 0);
`ifdef CLK_METER_MINMAX_EN
        check({tag, "_min"}, min_period, MAXV);
        check({tag, "_max"}, max_period, 0);
`endif
    endtask

    initial begin
        int hi, lo;
        #1;
        check_reset_vals("rst0");
        repeat (4) tick();
        rst = 1'b0;
        repeat (3) tick();

        // period 4, 50% duty
        wave(2, 2, 8);
        check("p4_period", period, 4);
        check("p4_high", high_time, 2);
        check("p4_active", active, 1);

        // period 6, 1 high / 5 low
        wave(1, 5, 5);
        check("p6_period", period, 6);
        check("p6_high", high_time, 1);

        // overflow: one edge, then held low
        sig_in = 1'b1; tick();
        sig_in = 1'b0;
        repeat (300) tick();
        check("ovf_flag", ovf, 1);
        check("ovf_active", active, 0);
        check("ovf_period", period, 6);

        // measurement resumes, ovf stays sticky
        wave(2, 3, 4);
        check("resume_period", period, 5);
        check("resume_high", high_time, 2);
        check("resume_ovf", ovf, 1);

        // clr coincident with a detected edge
        sig_in = 1'b1; tick(); tick();
        clr = 1'b1; tick();
        clr = 1'b0;
        check("clr_valid", valid, 0);
        check("clr_period", period, 0);
        check("clr_active", active, 0);
        check("clr_ovf", ovf, 0);
        sig_in = 1'b0; repeat (3) tick();
        wave(4, 4, 2);
        sig_in = 1'b1; repeat (4) tick();
        sig_in = 1'b0; tick();
        check("p8_period", period, 8);
        check("p8_high", high_time, 4);

        // asynchronous reset mid-period
        wave(5, 5, 2);
        sig_in = 1'b1; tick(); tick();
        rst = 1'b1;
        #1;
        check_reset_vals("rstmid");
        repeat (4) tick();
        rst = 1'b0;
        wave(3, 4, 3);
        check("p7_period", period, 7);
        check("p7_high", high_time, 3);

        // randomized traffic, with occasional overflow gaps and clears
        repeat (150) begin
            hi = $urandom_range(1, 8);
            lo = $urandom_range(1, 12);
            if ($urandom_range(0, 24) == 0) lo = 270;
            wave(hi, lo, 1);
            if ($urandom_range(0, 19) == 0) begin
                clr = 1'b1; tick(); clr = 1'b0;
            end
        end

        // min/max tracking over periods 4, 10, 6
        sig_in = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (2) tick();
        wave(2, 2, 1);
        wave(5, 5, 1);
        wave(3, 3, 1);
        sig_in = 1'b1; repeat (4) tick();
        sig_in = 1'b0; tick();
        check("mm_period", period, 6);
`ifdef CLK_METER_MINMAX_EN
        check("mm_min", min_period, 4);
        check("mm_max", max_period, 10);
        clr = 1'b1; tick(); clr = 1'b0;
        check("mm_clr_min", min_period, MAXV);
        check("mm_clr_max", max_period, 0);
`endif
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous clock-like signal (typically the divided CPU clock or a game tick) in cycles of the fast system clock `clk`. It recovers the division ratio that the clock divider produces, so software and the bench can confirm the selected CPU clock rate at runtime. It sits beside the clock divider in the top level. Its results feed the debug display or a memory-mapped status register.

## Interface
- `CNT_W`, 32: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, 2: number of synchronizer flops on `sig_in`; legal values are 2 or more.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sig_in`  in  1  measured signal, asynchronous to `clk`.
- `clr`  in  1  synchronous clear; same effect as reset, except that the synchronizer is not cleared.
- `period`  out  CNT_W  last completed period, in `clk` cycles.
- `high_time`  out  CNT_W  cycles the synchronized signal was high during that period.
- `valid`  out  1  one-cycle pulse; `period` and `high_time` updated this cycle.
- `active`  out  1  high while in state MEASURE.
- `ovf`  out  1  sticky flag: a period exceeded the counter range.
- `min_period`, `max_period`  out  CNT_W  present only with `CLK_METER_MINMAX_EN`.

## Operation
- `sig_in` passes through `SYNC_STAGES` flops to give `s`. A rising edge is `s & ~s_d`, where `s_d` is `s` delayed by one cycle.
- State IDLE:
  - Wait for an edge.
  - On an edge: go to MEASURE, set `cnt` to 1, set `hcnt` to 1.
- State MEASURE, every cycle without an edge:
  - `cnt` increments.
  - `hcnt` increments when `s` is 1.
- State MEASURE, on an edge:
  - `period` is loaded with `cnt` and `high_time` with `hcnt`.
  - `valid` is 1 in the next cycle.
  - `cnt` and `hcnt` restart at 1; the state stays MEASURE.
  - Result: edges detected at cycles t and t+N give `period` = N.
- Overflow:
  - Condition: in MEASURE with `cnt` all-ones and no edge.
  - Effect: set `ovf`, go to IDLE, leave `period` and `high_time` unchanged, no `valid`.
- `clr`:
  - Returns the block to IDLE.
  - Zeroes `period`, `high_time` and `ovf`, and suppresses `valid`.
  - If `clr` and an edge occur in the same cycle, `clr` wins and the edge is discarded.
- Counters never wrap; the overflow path always catches the all-ones value first.

## Timing
- Reset values:
  - `period`, `high_time`, `cnt`, `hcnt` = 0.
  - `valid`, `active`, `ovf` = 0.
  - State IDLE; synchronizer flops = 0.
  - `min_period` = all-ones, `max_period` = 0.
- Latency from an `sig_in` rising transition to edge detection is `SYNC_STAGES` or `SYNC_STAGES`+1 cycles.
- `valid` asserts 1 cycle after the detecting edge and lasts exactly 1 cycle.
- `active` goes high 1 cycle after the first edge, and low 1 cycle after overflow or `clr`.
- Reset in the middle of a measurement abandons it immediately; the first `valid` after reset needs two edges.
- Minimum measurable period is 2 cycles. A `sig_in` running faster than `clk`/2 produces aliased values, and no error is flagged.

## Configuration
- `CLK_METER_MINMAX_EN` defined:
  - Ports `min_period` and `max_period` exist.
  - On each `valid` they update to min(`min_period`, `period`) and max(`max_period`, `period`).
  - The update is visible in the same cycle as `valid`.
  - `clr` and reset restore all-ones and 0.
- Not defined: the ports and registers are absent, and the remaining behaviour is identical.

## Test plan
- Period 4, duty 50%: `sig_in` toggles every 2 `clk` cycles.
  - No `valid` after the first edge.
  - Then `period`=4, `high_time`=2, with a `valid` pulse every 4 cycles.
  - `active`=1.
- Period 6, 1 high / 5 low: `period`=6, `high_time`=1 on every `valid`.
- Overflow: `CNT_W`=8, one edge, then `sig_in` held low.
  - `ovf`=1 and `active`=0 about 255 cycles after the edge.
  - `period` keeps its last value and no `valid` occurs.
  - The next edges resume measurement while `ovf` stays 1.
- `clr` in the same cycle as a detected edge: no `valid`, `period`=0, state IDLE, `ovf` cleared. Two further edges 8 cycles apart give `period`=8.
- `rst` pulsed mid-period: all outputs return to their reset values at once. Measurement restarts only after two new edges.
- With `CLK_METER_MINMAX_EN`: periods 4, 10, 6 in sequence give `min_period`=4 and `max_period`=10. After `clr`, they read all-ones and 0.
